// File: rtl/hawk_axi_mem_resp.sv
// hawk_axi_mem_resp
//   AXI4 responder backed by an on-chip word-addressed array. It terminates
//   the 256-bit HACD master port for standalone simulation and FPGA bring-up.
//   Independent write and read engines each hold one outstanding burst. The
//   engines support INCR and FIXED bursts with byte strobes. A WRAP burst, a
//   reserved burst type or an oversize beat is answered with SLVERR and never
//   touches the array.
//
// Optional feature:
//   HAWK_AXI_MEM_RESP_BP_EN - a free-running 2-bit counter drops awready,
//   wready and arready on every 4th cycle to give periodic backpressure.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   axi_aw*  (in)        write address channel, axi_awready out
//   axi_w*   (in)        write data channel, axi_wready out
//   axi_b*   (out)       write response channel, axi_bready in
//   axi_ar*  (in)        read address channel, axi_arready out
//   axi_r*   (out)       read data channel, axi_rready in
//   lock/cache/prot/qos/region/user inputs are accepted and ignored.
module hawk_axi_mem_resp #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 6,
  parameter int USER_W     = 1,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // AW
  input  logic [ID_W-1:0]     axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awlock,
  input  logic [3:0]          axi_awcache,
  input  logic [2:0]          axi_awprot,
  input  logic [3:0]          axi_awqos,
  input  logic [3:0]          axi_awregion,
  input  logic [USER_W-1:0]   axi_awuser,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  // W
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic [USER_W-1:0]   axi_wuser,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  // B
  output logic [ID_W-1:0]     axi_bid,
  output logic [1:0]          axi_bresp,
  output logic [USER_W-1:0]   axi_buser,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  // AR
  input  logic [ID_W-1:0]     axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arlock,
  input  logic [3:0]          axi_arcache,
  input  logic [2:0]          axi_arprot,
  input  logic [3:0]          axi_arqos,
  input  logic [3:0]          axi_arregion,
  input  logic [USER_W-1:0]   axi_aruser,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  // R
  output logic [ID_W-1:0]     axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic [USER_W-1:0]   axi_ruser,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] LB3 = 3'(LB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> (DEPTH_LOG2 + LB)) == '0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[DEPTH_LOG2+LB-1:LB];
  endfunction

  // WRAP and the reserved encoding both have burst[1] set.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] | (size > LB3);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic fixed);
    return fixed ? a : a + (ADDR_W'(1) << size);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Backpressure stall
  logic bp_stall;
`ifdef HAWK_AXI_MEM_RESP_BP_EN
  logic [1:0] bp_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) bp_cnt_q <= 2'd0;
    else       bp_cnt_q <= bp_cnt_q + 2'd1;
  end
  assign bp_stall = (bp_cnt_q == 2'd3);
`else
  assign bp_stall = 1'b0;
`endif

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  w_state_e          w_state_q;
  logic [ID_W-1:0]   wid_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wlen_q;
  logic [7:0]        wcnt_q;
  logic [2:0]        wsize_q;
  logic              wfixed_q;
  logic              werr_q;   // whole-burst error, no array writes
  logic              wbad_q;   // sticky per-beat error seen so far
  logic [1:0]        bresp_q;
  logic              aw_hs, w_hs, b_hs, w_beat_ok, w_last_beat, w_beat_bad;

  assign axi_awready = (w_state_q == W_IDLE) & ~rst_i & ~bp_stall;
  assign axi_wready  = (w_state_q == W_DATA) & ~rst_i & ~bp_stall;
  assign axi_bvalid  = (w_state_q == W_RESP) & ~rst_i;
  assign axi_bid     = wid_q;
  assign axi_bresp   = bresp_q;
  assign axi_buser   = '0;

  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;
  assign b_hs        = axi_bvalid & axi_bready;
  assign w_last_beat = (wcnt_q == wlen_q);
  assign w_beat_ok   = ~werr_q & in_range(waddr_q);
  // wlast must appear on the final beat and nowhere else.
  assign w_beat_bad  = ~in_range(waddr_q) | (axi_wlast != w_last_beat);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
      wbad_q    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          wid_q     <= axi_awid;
          waddr_q   <= axi_awaddr;
          wlen_q    <= axi_awlen;
          wsize_q   <= axi_awsize;
          wfixed_q  <= (axi_awburst == BURST_FIXED);
          werr_q    <= burst_err(axi_awburst, axi_awsize);
          wbad_q    <= 1'b0;
          wcnt_q    <= '0;
          w_state_q <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          waddr_q <= next_addr(waddr_q, wsize_q, wfixed_q);
          wcnt_q  <= wcnt_q + 8'd1;
          wbad_q  <= wbad_q | w_beat_bad;
          if (w_last_beat) begin
            bresp_q   <= (werr_q | wbad_q | w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (b_hs) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Array is not reset; w_hs is already blocked while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (w_hs && w_beat_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_wstrb[b]) mem_q[word_idx(waddr_q)][b*8 +: 8] <= axi_wdata[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  r_state_e          r_state_q;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [7:0]        rlen_q;
  logic [7:0]        rcnt_q;
  logic [2:0]        rsize_q;
  logic              rfixed_q;
  logic              rerr_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ar_hs, r_hs;
  logic [ADDR_W-1:0] r_next;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic              r_fetch_ok;
  logic [DATA_W-1:0] r_word;

  assign axi_arready = (r_state_q == R_IDLE) & ~rst_i & ~bp_stall;
  assign axi_rvalid  = rvalid_q & ~rst_i;
  assign axi_rid     = rid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q;
  assign axi_ruser   = '0;

  assign ar_hs = axi_arvalid & axi_arready;
  assign r_hs  = axi_rvalid & axi_rready;

  // The beat being registered: the first beat comes straight from AR,
  // later beats from the advanced burst address.
  assign r_next       = next_addr(raddr_q, rsize_q, rfixed_q);
  assign r_fetch_addr = (r_state_q == R_IDLE) ? axi_araddr : r_next;
  assign r_fetch_ok   = ~((r_state_q == R_IDLE) ? burst_err(axi_arburst, axi_arsize) : rerr_q)
                        & in_range(r_fetch_addr);
  // Registered read of the pre-edge array gives old data on a same-cycle write.
  assign r_word       = mem_q[word_idx(r_fetch_addr)];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rfixed_q  <= 1'b0;
      rerr_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          rid_q     <= axi_arid;
          raddr_q   <= axi_araddr;
          rlen_q    <= axi_arlen;
          rsize_q   <= axi_arsize;
          rfixed_q  <= (axi_arburst == BURST_FIXED);
          rerr_q    <= burst_err(axi_arburst, axi_arsize);
          rcnt_q    <= '0;
          rdata_q   <= r_fetch_ok ? r_word : '0;
          rresp_q   <= r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
          rlast_q   <= (axi_arlen == 8'd0);
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: if (r_hs) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            r_state_q <= R_IDLE;
          end else begin
            raddr_q <= r_next;
            rcnt_q  <= rcnt_q + 8'd1;
            rdata_q <= r_fetch_ok ? r_word : '0;
            rresp_q <= r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awregion,
                       axi_awuser, axi_wuser, axi_arlock, axi_arcache, axi_arprot,
                       axi_arqos, axi_arregion, axi_aruser};

endmodule

// File: tb/tb_hawk_axi_mem_resp.sv
// Directed bench for hawk_axi_mem_resp: a table of write/read bursts with
// hand-computed responses and data, plus sequences for reset, R-channel
// hold under rready=0, reset mid-burst and the optional backpressure.
module tb_hawk_axi_mem_resp;

  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] MIX  = {{224{1'b1}}, 32'h1234_5678};
  localparam logic [31:0]  ALL  = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   awid = '0, arid = '0;
  logic [63:0]  awaddr = '0, araddr = '0;
  logic [7:0]   awlen = '0, arlen = '0;
  logic [2:0]   awsize = '0, arsize = '0;
  logic [1:0]   awburst = '0, arburst = '0;
  logic         awvalid = 1'b0, arvalid = 1'b0;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '0;
  logic         wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic         awready, wready, bvalid, arready, rvalid, rlast;
  logic [5:0]   bid, rid;
  logic [1:0]   bresp, rresp;
  logic [255:0] rdata;
  logic [0:0]   buser, ruser;

  hawk_axi_mem_resp dut (
    .clk_i(clk), .rst_i(rst),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
    .axi_awburst(awburst), .axi_awlock(1'b0), .axi_awcache(4'd0), .axi_awprot(3'd0),
    .axi_awqos(4'd0), .axi_awregion(4'd0), .axi_awuser(1'b0),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wuser(1'b0),
    .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_buser(buser), .axi_bvalid(bvalid),
    .axi_bready(bready),
    .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
    .axi_arburst(arburst), .axi_arlock(1'b0), .axi_arcache(4'd0), .axi_arprot(3'd0),
    .axi_arqos(4'd0), .axi_arregion(4'd0), .axi_aruser(1'b0),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
    .axi_ruser(ruser), .axi_rvalid(rvalid), .axi_rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  typedef struct {
    bit                wr;
    logic [5:0]        id;
    logic [63:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [31:0]       strb;
    int                wl;      // beat index carrying wlast
    logic [3:0][255:0] d;       // write data, or expected read data
    logic [1:0]        bresp;
    logic [7:0]        rresp;   // 2 bits per beat
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit wr, input logic [5:0] id, input logic [63:0] addr,
                     input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                     input logic [31:0] strb, input int wl,
                     input logic [255:0] d0, input logic [255:0] d1,
                     input logic [255:0] d2, input logic [255:0] d3,
                     input logic [1:0] br, input logic [7:0] rr);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.strb = strb; v.wl = wl; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.bresp = br; v.rresp = rr;
    vecs.push_back(v);
  endtask

  task automatic do_write(input vec_t v);
    int n;
    @(negedge clk);
    awvalid = 1'b1; awid = v.id; awaddr = v.addr; awlen = v.len;
    awsize = v.size; awburst = v.burst;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("aw_ready");
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      @(negedge clk);
`ifndef HAWK_AXI_MEM_RESP_BP_EN
      if (i == 0) chk("w_ready_latency", {255'd0, wready}, 256'd1);
`endif
      wvalid = 1'b1; wdata = v.d[i]; wstrb = v.strb; wlast = (i == v.wl);
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("w_ready");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("b_valid_latency", {255'd0, bvalid}, 256'd1);
    chk("b_id", {250'd0, bid}, {250'd0, v.id});
    chk("b_resp", {254'd0, bresp}, {254'd0, v.bresp});
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    chk("b_valid_drop", {255'd0, bvalid}, 256'd0);
  endtask

  task automatic do_read(input vec_t v);
    int n;
    @(negedge clk);
    arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len;
    arsize = v.size; arburst = v.burst;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("ar_ready");
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i <= int'(v.len); i++) begin
      @(negedge clk);
      if (i == 0) chk("r_valid_latency", {255'd0, rvalid}, 256'd1);
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("r_valid");
      chk("r_data", rdata, v.d[i]);
      chk("r_resp", {254'd0, rresp}, {254'd0, v.rresp[2*i +: 2]});
      chk("r_last", {255'd0, rlast}, {255'd0, (i == int'(v.len))});
      chk("r_id", {250'd0, rid}, {250'd0, v.id});
      @(posedge clk); #1;
    end
    rready = 1'b0;
    @(negedge clk);
    chk("r_valid_drop", {255'd0, rvalid}, 256'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lows;
    int n;
    // INCR writes/reads, strobes, FIXED, error bursts, range edge, bad wlast.
    add(1, 6'd5,  64'h40,   8'd3, 3'd5, 2'b01, ALL, 3, 256'hA0, 256'hA1, 256'hA2, 256'hA3, 2'b00, 8'h00);
    add(0, 6'd9,  64'h40,   8'd3, 3'd5, 2'b01, ALL, 0, 256'hA0, 256'hA1, 256'hA2, 256'hA3, 2'b00, 8'h00);
    add(1, 6'd1,  64'h40,   8'd0, 3'd5, 2'b01, ALL, 0, ONES, 0, 0, 0, 2'b00, 8'h00);
    add(1, 6'd2,  64'h40,   8'd0, 3'd5, 2'b01, 32'hF, 0, 256'h1234_5678, 0, 0, 0, 2'b00, 8'h00);
    add(0, 6'd3,  64'h40,   8'd0, 3'd5, 2'b01, ALL, 0, MIX, 0, 0, 0, 2'b00, 8'h00);
    add(1, 6'd4,  64'h80,   8'd2, 3'd5, 2'b00, ALL, 2, 256'd1, 256'd2, 256'd3, 0, 2'b00, 8'h00);
    add(0, 6'd6,  64'h80,   8'd1, 3'd5, 2'b00, ALL, 0, 256'd3, 256'd3, 0, 0, 2'b00, 8'h00);
    add(0, 6'd7,  64'h60,   8'd2, 3'd5, 2'b01, ALL, 0, 256'hA1, 256'd3, 256'hA3, 0, 2'b00, 8'h00);
    add(1, 6'd8,  64'h40,   8'd3, 3'd5, 2'b10, ALL, 1, 256'h55, 256'h56, 256'h57, 256'h58, 2'b10, 8'h00);
    add(0, 6'd10, 64'h40,   8'd1, 3'd5, 2'b01, ALL, 0, MIX, 256'hA1, 0, 0, 2'b00, 8'h00);
    add(0, 6'd11, 64'h40,   8'd1, 3'd5, 2'b10, ALL, 0, 0, 0, 0, 0, 2'b00, 8'h0A);
    add(1, 6'd12, 64'h60,   8'd0, 3'd6, 2'b01, ALL, 0, 256'h77, 0, 0, 0, 2'b10, 8'h00);
    add(0, 6'd13, 64'h60,   8'd0, 3'd5, 2'b01, ALL, 0, 256'hA1, 0, 0, 0, 2'b00, 8'h00);
    add(1, 6'd14, 64'h7FE0, 8'd0, 3'd5, 2'b01, ALL, 0, 256'hBEEF, 0, 0, 0, 2'b00, 8'h00);
    add(1, 6'd15, 64'h8000, 8'd0, 3'd5, 2'b01, ALL, 0, 256'h99, 0, 0, 0, 2'b10, 8'h00);
    add(0, 6'd16, 64'h7FE0, 8'd1, 3'd5, 2'b01, ALL, 0, 256'hBEEF, 0, 0, 0, 2'b00, 8'h08);
    add(1, 6'd17, 64'hA0,   8'd1, 3'd5, 2'b01, ALL, -1, 256'd9, 256'd10, 0, 0, 2'b10, 8'h00);
    add(0, 6'd18, 64'hA0,   8'd1, 3'd5, 2'b01, ALL, 0, 256'd9, 256'd10, 0, 0, 2'b00, 8'h00);

    // Reset: all readies/valids low while held, idle values after release.
    repeat (3) @(negedge clk);
    chk("rst_awready", {255'd0, awready}, 256'd0);
    chk("rst_arready", {255'd0, arready}, 256'd0);
    chk("rst_bvalid",  {255'd0, bvalid},  256'd0);
    chk("rst_rvalid",  {255'd0, rvalid},  256'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_awready", {255'd0, awready}, 256'd1);
    chk("idle_arready", {255'd0, arready}, 256'd1);
    chk("idle_wready",  {255'd0, wready},  256'd0);
    chk("idle_rdata",   rdata, 256'd0);
    chk("idle_bresp",   {254'd0, bresp}, 256'd0);
    chk("idle_rresp",   {254'd0, rresp}, 256'd0);
    chk("idle_ids",     {244'd0, bid, rid}, 256'd0);

    foreach (vecs[k]) begin
      if (vecs[k].wr) do_write(vecs[k]);
      else            do_read(vecs[k]);
    end

    // Out-of-range read held with rready low for 5 cycles.
    @(negedge clk);
    arvalid = 1'b1; arid = 6'd33; araddr = 64'h8000; arlen = 8'd0;
    arsize = 3'd5; arburst = 2'b01;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("hold_arready");
    @(posedge clk); #1 arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_rvalid", {255'd0, rvalid}, 256'd1);
      chk("hold_rdata", rdata, 256'd0);
      chk("hold_rresp", {254'd0, rresp}, {254'd0, 2'b10});
      chk("hold_rid", {250'd0, rid}, 256'd33);
    end
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("hold_done", {255'd0, rvalid}, 256'd0);

    // Reset during beat 2 of a 4-beat read.
    @(negedge clk);
    arvalid = 1'b1; arid = 6'd40; araddr = 64'h40; arlen = 8'd3;
    arsize = 3'd5; arburst = 2'b01;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("mid_arready");
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    chk("mid_beat1", rdata, MIX);
    @(posedge clk); #1;
    chk("mid_beat2_valid", {255'd0, rvalid}, 256'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", {255'd0, rvalid}, 256'd0);
    @(negedge clk);
    chk("mid_rst_arready", {255'd0, arready}, 256'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_rvalid", {255'd0, rvalid}, 256'd0);
`ifndef HAWK_AXI_MEM_RESP_BP_EN
      chk("post_rst_arready", {255'd0, arready}, 256'd1);
`endif
    end
    rready = 1'b0;

    // Backpressure pattern on awready while idle.
    lows = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!awready) lows++;
    end
`ifdef HAWK_AXI_MEM_RESP_BP_EN
    chk("bp_awready_lows", 256'(lows), 256'd2);
`else
    chk("bp_awready_lows", 256'(lows), 256'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
